// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between a data port (0) and a fetch port (1)
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/we_i/addr*_i/wdata*_i per-port requests;
// gnt_o acceptance pulse; rvalid_o/rdata_o/err_o completion; busy_o high in WAIT; mem_* shared-memory side.
module mem_arbiter #(
  parameter int BITNESS = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         req_i,
  input  logic [1:0]         we_i,
  input  logic [BITNESS-1:0] addr0_i,
  input  logic [BITNESS-1:0] addr1_i,
  input  logic [BITNESS-1:0] wdata0_i,
  input  logic [BITNESS-1:0] wdata1_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         rvalid_o,
  output logic [BITNESS-1:0] rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [BITNESS-1:0] mem_addr_o,
  output logic [BITNESS-1:0] mem_wdata_o,
  input  logic [BITNESS-1:0] mem_rdata_i,
  input  logic               mem_ready_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic               last, owner, we_q, sel, grant, tmo, done;
  logic [BITNESS-1:0] addr_q, wdata_q;
  // gnt_o is combinational, so it is gated by rst_ni to stay low while reset is held
  always_comb begin
    sel   = &req_i ? ~last : req_i[1];
    grant = rst_ni && state == IDLE && |req_i;
    gnt_o = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
    tmo   = state == WAIT && !mem_ready_i && cnt == CW'(TIMEOUT - 1);
    done  = state == WAIT && (mem_ready_i || tmo);
  end
  assign busy_o      = state == WAIT;
  assign mem_req_o   = busy_o;
  assign mem_we_o    = busy_o & we_q;
  assign mem_addr_o  = busy_o ? addr_q : '0;
  assign mem_wdata_o = busy_o ? wdata_q : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_o <= 2'b00;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= done ? (owner ? 2'b10 : 2'b01) : 2'b00;
      err_o    <= tmo;
      rdata_o  <= (state == WAIT && mem_ready_i && !we_q) ? mem_rdata_i : '0;
      if (grant) begin
        state   <= WAIT;
        cnt     <= '0;
        last    <= sel;
        owner   <= sel;
        we_q    <= sel ? we_i[1] : we_i[0];
        addr_q  <= sel ? addr1_i : addr0_i;
        wdata_q <= sel ? wdata1_i : wdata0_i;
      end else if (done) begin
        state <= IDLE;
      end else if (busy_o) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with TIMEOUT=4
module tb_mem_arbiter;
  logic        clk, rst_n, err, busy, mem_req, mem_we, mem_ready;
  logic [1:0]  req, we, gnt, rvalid;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, failures = 0;
  typedef struct {logic [1:0] port; logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  mem_arbiter #(.BITNESS(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (rvalid !== 2'b00) begin
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL rvalid_unexpected got rvalid=%b rdata=%h err=%b want none", rvalid, rdata, err);
    end else begin
      e_m = sb.pop_front();
      if ({rvalid, rdata, err} !== {e_m.port, e_m.rdata, e_m.err}) begin
        failures++;
        $display("FAIL completion got rvalid=%b rdata=%h err=%b want rvalid=%b rdata=%h err=%b",
                 rvalid, rdata, err, e_m.port, e_m.rdata, e_m.err);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic test_reset();
    rst_n = 1'b0; req = 2'b11; we = 2'b11; addr0 = 32'h1; addr1 = 32'h2;
    wdata0 = 32'h3; wdata1 = 32'h4; mem_ready = 1'b1; mem_rdata = 32'h5;
    #1;
    checks++;
    if ({gnt, rvalid, rdata, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h err=%b busy=%b want all 0", gnt, rvalid, rdata, err, busy);
    end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, busy, mem_req} !== 3'b000) begin
      failures++;
      $display("FAIL reset_held got gnt=%b busy=%b mem_req=%b want 0", gnt, busy, mem_req);
    end
    req = 2'b00; we = 2'b00; mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_single_read();
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 32'h100;
    #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL read_gnt got %b want 01", gnt); end
    sb.push_back('{2'b01, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    req = 2'b00; addr0 = 32'h0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, busy, gnt} !== {1'b1, 1'b0, 32'h100, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL read_wait got req=%b we=%b addr=%h busy=%b gnt=%b want 1 0 00000100 1 00", mem_req, mem_we, mem_addr, busy, gnt);
    end
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if ({busy, mem_req, mem_addr} !== '0) begin
      failures++;
      $display("FAIL read_idle got busy=%b mem_req=%b addr=%h want 0", busy, mem_req, mem_addr);
    end
  endtask
  task automatic test_write();
    @(negedge clk);
    req = 2'b10; we = 2'b10; addr1 = 32'h20; wdata1 = 32'h55;
    #1;
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL write_gnt got %b want 10", gnt); end
    sb.push_back('{2'b10, 32'h0, 1'b0});
    @(negedge clk);
    req = 2'b00; we = 2'b00; addr1 = 32'hBAD; wdata1 = 32'hBAD;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h55}) begin
      failures++;
      $display("FAIL write_wait got req=%b we=%b addr=%h wdata=%h want 1 1 00000020 00000055", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask
  task automatic test_back_to_back();
    logic [1:0] exp;
    @(negedge clk);
    rst_n = 1'b0; req = 2'b11; we = 2'b00; mem_ready = 1'b1; mem_rdata = 32'hC0FFEE00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      exp = (j % 2) ? 2'b00 : ((j % 4 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (gnt !== exp) begin failures++; $display("FAIL rr_gnt_%0d got %b want %b", j, gnt, exp); end
      if (exp != 2'b00) sb.push_back('{exp, 32'hC0FFEE00, 1'b0});
    end
    @(negedge clk);
    req = 2'b00; mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask
  task automatic test_timeout();
    int waits = 0;
    bit seen = 0;
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 32'h44; mem_ready = 1'b0; mem_rdata = 32'h77777777;
    #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL timeout_gnt got %b want 01", gnt); end
    sb.push_back('{2'b01, 32'h0, 1'b1});
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      if (rvalid !== 2'b00) seen = 1;
      else if (busy) waits++;
    end
    checks++;
    if (!seen || waits != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_waits got waits=%0d seen=%0d busy=%b want 4 1 0", waits, seen, busy);
    end
    mem_rdata = 32'h0;
  endtask
  task automatic test_ready_last();
    @(negedge clk);
    req = 2'b10; we = 2'b00; addr1 = 32'h88;
    #1;
    checks++;
    if (gnt !== 2'b10) begin failures++; $display("FAIL last_gnt got %b want 10", gnt); end
    sb.push_back('{2'b10, 32'h12345678, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req = 2'b00;
      mem_ready = (k == 4);
      mem_rdata = (k == 4) ? 32'h12345678 : 32'h0;
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL last_busy got %b want 1", busy); end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL last_idle got busy=%b want 0", busy); end
  endtask
  task automatic test_reset_mid_wait();
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL abort_gnt got %b want 01", gnt); end
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, busy, mem_addr} !== '0) begin
      failures++;
      $display("FAIL abort_async got mem_req=%b busy=%b addr=%h want 0", mem_req, busy, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    req = 2'b11;
    #1;
    checks++;
    if (gnt !== 2'b01) begin failures++; $display("FAIL abort_tie got %b want 01", gnt); end
    sb.push_back('{2'b01, 32'hABCD0123, 1'b0});
    @(negedge clk);
    req = 2'b00; mem_ready = 1'b1; mem_rdata = 32'hABCD0123;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_ready_last();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got %0d pending want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BITNESS, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 15, maximum WAIT cycles before the error response; legal range 1..255.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  2  per-port request; bit 0 = data port, bit 1 = fetch port.
REQ-006 we_i  input  2  per-port write enable; 1 = write, 0 = read.
REQ-007 addr0_i / addr1_i  input  BITNESS each  per-port address.
REQ-008 wdata0_i / wdata1_i  input  BITNESS each  per-port write data.
REQ-009 gnt_o  output  2  one-hot acceptance pulse per port.
REQ-010 rvalid_o  output  2  one-hot completion pulse per port.
REQ-011 rdata_o  output  BITNESS  read data, valid while any rvalid_o bit is high.
REQ-012 err_o  output  1  timeout flag, qualified by rvalid_o.
REQ-013 busy_o  output  1  high when state is WAIT.
REQ-014 mem_req_o, mem_we_o  output  1 each  shared-memory request and write enable.
REQ-015 mem_addr_o, mem_wdata_o  output  BITNESS each  shared-memory address and write data.
REQ-016 mem_rdata_i  input  BITNESS  shared-memory read data.
REQ-017 mem_ready_i  input  1  shared-memory completion, valid while mem_req_o is high.

Function
REQ-018 The FSM SHALL have two states: IDLE and WAIT.
REQ-019 In IDLE with req_i nonzero, the block SHALL combinationally assert exactly one gnt_o bit, latch that port's we/addr/wdata, and enter WAIT next cycle.
REQ-020 Tie-break SHALL be round-robin: when both ports request, grant the port not granted last; a lone requester SHALL always be granted.
REQ-021 The last-granted pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until their gnt_o bit is high; after the grant, the inputs are don't-care.
REQ-023 In WAIT, mem_req_o SHALL be 1 and mem_we_o/mem_addr_o/mem_wdata_o SHALL equal the latched values; in IDLE, all mem_* outputs SHALL be 0.
REQ-024 gnt_o SHALL be 0 in WAIT; requests SHALL queue by remaining asserted.
REQ-025 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ready_i.
REQ-026 mem_ready_i high in WAIT SHALL cause a return to IDLE and, next cycle, a one-cycle pulse on rvalid_o for the owning port, with err_o=0.
REQ-027 On a read completion, rdata_o SHALL be mem_rdata_i registered from the ready cycle; on a write completion, rdata_o SHALL be 0.
REQ-028 If the counter reaches TIMEOUT-1 with mem_ready_i low, the block SHALL return to IDLE and pulse rvalid_o with err_o=1 and rdata_o=0.
REQ-029 mem_ready_i in the same cycle as the timeout condition SHALL win: normal completion, err_o=0.
REQ-030 mem_ready_i in IDLE SHALL be ignored.
REQ-031 Minimum latency SHALL be: grant at cycle N, mem_req_o at N+1, rvalid_o at N+2 when ready is at N+1.
REQ-032 A new grant MAY coincide with the previous rvalid_o cycle, giving back-to-back grants every 2 cycles.
REQ-033 The counter width SHALL be $clog2(TIMEOUT+1) and the counter SHALL never wrap.

Reset
REQ-034 rst_ni low SHALL immediately force state IDLE, counter 0, pointer to port 1, and all outputs (gnt_o, rvalid_o, rdata_o, err_o, busy_o, mem_*) to 0, independent of clk_i.
REQ-035 Reset during WAIT SHALL abort the transaction: mem_req_o drops asynchronously and no rvalid_o is ever produced for it.
REQ-036 The first grant SHALL be possible in the first rising edge cycle after rst_ni deasserts.

Verification
REQ-037 Single read: req_i=01, addr0=0x100, memory ready 1 cycle later, rdata=0xDEADBEEF -> gnt_o=01 at N, mem_addr_o=0x100 at N+1, rvalid_o=01 with rdata_o=0xDEADBEEF at N+2.
REQ-038 Contention: req_i=11 held from reset, ready each cycle -> grants alternate 01,10,01,10 every 2 cycles with no starvation.
REQ-039 Write: req_i=10, we_i=10, addr1=0x20, wdata1=0x55 -> mem_we_o=1, mem_wdata_o=0x55 during WAIT; rvalid_o=10, rdata_o=0.
REQ-040 Timeout: TIMEOUT=4, mem_ready_i held 0 -> exactly 4 WAIT cycles, then rvalid_o pulse with err_o=1, rdata_o=0, busy_o=0.
REQ-041 Ready on the last count: TIMEOUT=4, ready in the 4th WAIT cycle -> err_o=0 and normal data returned.
REQ-042 Reset mid-WAIT: rst_ni=0 in the 2nd WAIT cycle -> mem_req_o=0 before the next edge; no rvalid_o after release; the next tie grants port 0.
